elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
Sequential controller for the 5-floor elevator car. Latches hall/car call requests, picks the travel direction with a SCAN policy (continue in the current direction while calls remain ahead, otherwise reverse), and times travel between floors and door dwell. It drives currentFloor, up, down and doorIsOpen, which feed the floor display decoder and door logic.

Parameters:
NUM_FLOORS, 5, number of floors (0..NUM_FLOORS-1); floor index width is 3 bits.
TRAVEL_CYCLES, 8, clock cycles per one-floor move (>=2).
DOOR_CYCLES, 4, clock cycles the door stays open after arrival or last re-open (>=2).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
callReq  in  NUM_FLOORS  one bit per floor; sampled every edge; a high bit registers a call (pulse or level).
doorBlock  in  1  obstruction sensor; high while door open holds it open.
currentFloor  out  3  registered floor index.
up  out  1  registered; high while in MOVE_UP.
down  out  1  registered; high while in MOVE_DOWN.
doorIsOpen  out  1  registered; high while in DOOR_OPEN.
pending  out  NUM_FLOORS  registered outstanding call vector.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset: state IDLE, currentFloor=0, up=down=doorIsOpen=0, pending=0, lastDir=UP, timers=0. Reset asserted mid-move or mid-dwell aborts immediately to these values.
- Call capture: every edge pending <= pending | callReq, except the bit for currentFloor on an edge where the state is or becomes DOOR_OPEN; that bit is cleared, and a callReq there restarts the door timer instead.
- above = any pending bit > currentFloor; below = any pending bit < currentFloor. Decisions use the registered pending, giving a 1-cycle request-to-response latency.
- IDLE: if pending[currentFloor] -> DOOR_OPEN. Else if above and below -> move in lastDir. Else above -> MOVE_UP. Else below -> MOVE_DOWN. Else stay.
- MOVE_UP/MOVE_DOWN: on entry, travel timer loads TRAVEL_CYCLES-1 and decrements each edge. On the edge where it is 0, currentFloor steps +/-1 and the timer reloads. Using the new floor on that same edge: if its pending bit is set -> DOOR_OPEN. Else if calls remain ahead -> keep moving. Else -> IDLE. lastDir is updated on entry.
- Floor bounds: never step above NUM_FLOORS-1 or below 0. If a move would exceed the bound, go to IDLE instead.
- DOOR_OPEN: on entry, door timer loads DOOR_CYCLES-1 and decrements each edge. doorBlock=1 or a call at currentFloor reloads it. On the edge where it is 0 (and not reloaded):
  - if lastDir has calls ahead -> continue in lastDir;
  - else if calls exist in the opposite direction -> reverse;
  - else -> IDLE.
- Outputs up/down/doorIsOpen are registered, mutually exclusive and change on the same edge as the state. At most one of them is high.
- Simultaneous calls above and below while idle: lastDir wins. Call at the floor being departed on the exit edge is kept pending and is served on return.

Decomposition:
- Package elevator_pkg: state encoding (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), direction constants (DIR_UP, DIR_DOWN), FLOOR_W=3, NUM_FLOORS default.
- Sub-module elev_timer: loadable down-counter with load, reload and done outputs, instanced twice (travel, door).
- Top holds the FSM, pending register and the above/below reduction.

Test Plan:
- Reset, then callReq=5'b01000 pulsed at edge 1 -> pending=01000 after edge 1; up=1 from edge 2; currentFloor 1/2/3 at edges 10/18/26; doorIsOpen=1 edges 26-29, pending=0; IDLE at edge 30.
- At floor 0 idle, callReq=5'b00001 -> doorIsOpen next edge for 4 cycles; pending[0] never set.
- Door open at floor 3, doorBlock held 10 cycles -> doorIsOpen stays high for those 10 cycles plus 4 after release.
- Car at floor 2 idle with lastDir=DOWN, calls 5'b10001 on the same edge -> down=1; serves floor 0 first, then reverses and serves floor 4.
- While moving up 0->4, callReq floor 1 arriving after the car passes floor 1 -> floor 1 served only after floor 4 dwell, on the down sweep.
- rst asserted mid-travel at floor 2 -> outputs and pending zero asynchronously; currentFloor=0; no movement after release without new calls.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 5;
  localparam int unsigned FLOOR_W    = 3;

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoorOpen} state_e;
  typedef enum logic {DirDown = 1'b0, DirUp = 1'b1} dir_e;

  // True when any pending call lies strictly beyond floor in the given direction.
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor,
                                       input logic                  go_up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (go_up ? (i > int'(floor)) : (i < int'(floor))) r = r | pend[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call inputs and car status outputs of the elevator controller.
interface elevator_scheduler_if;

  logic [elevator_pkg::NUM_FLOORS-1:0] callReq;
  logic                                doorBlock;
  logic [elevator_pkg::FLOOR_W-1:0]    currentFloor;
  logic                                up;
  logic                                down;
  logic                                doorIsOpen;
  logic [elevator_pkg::NUM_FLOORS-1:0] pending;

  modport master (
    output callReq, doorBlock,
    input  currentFloor, up, down, doorIsOpen, pending
  );

  modport slave (
    input  callReq, doorBlock,
    output currentFloor, up, down, doorIsOpen, pending
  );

endinterface

// File: rtl/elev_timer.sv
// Loadable down-counter that holds at zero; done is high while the count is zero.
module elev_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator controller: latches calls, picks direction, times travel and door dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input logic                 clk,
  input logic                 rst,
  elevator_scheduler_if.slave elev_io
);

  localparam int unsigned TimerW = 8;

  state_e                 state_q, state_d;
  dir_e                   last_dir_q, last_dir_d;
  logic [FLOOR_W-1:0]     floor_q, floor_d;
  logic [NUM_FLOORS-1:0]  pending_q, pending_d;
  logic                   up_q, down_q, door_q;
  logic                   tt_load, tt_done, dt_load, dt_done;
  logic                   go_valid, go_up, move_up, above, below;

  assign above   = calls_ahead(pending_q, floor_q, 1'b1);
  assign below   = calls_ahead(pending_q, floor_q, 1'b0);
  assign move_up = (state_q == StMoveUp);

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    tt_load    = 1'b0;
    dt_load    = 1'b0;
    go_valid   = 1'b0;
    go_up      = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q[floor_q] || elev_io.callReq[floor_q]) begin
          state_d = StDoorOpen;
          dt_load = 1'b1;
        end else if (above && below) begin
          go_valid = 1'b1;
          go_up    = (last_dir_q == DirUp);
        end else if (above || below) begin
          go_valid = 1'b1;
          go_up    = above;
        end
      end
      StMoveUp, StMoveDown: begin
        if (tt_done) begin
          if (move_up ? (floor_q == FLOOR_W'(NUM_FLOORS - 1)) : (floor_q == '0)) begin
            state_d = StIdle;
          end else begin
            floor_d = move_up ? floor_q + 1'b1 : floor_q - 1'b1;
            tt_load = 1'b1;
            // Arrival decisions look at the floor being entered on this edge.
            if (pending_q[floor_d]) begin
              state_d = StDoorOpen;
              dt_load = 1'b1;
            end else if (!calls_ahead(pending_q, floor_d, move_up)) begin
              state_d = StIdle;
            end
          end
        end
      end
      StDoorOpen: begin
        if (elev_io.doorBlock || elev_io.callReq[floor_q]) begin
          dt_load = 1'b1;
        end else if (dt_done) begin
          if (calls_ahead(pending_q, floor_q, last_dir_q == DirUp)) begin
            go_valid = 1'b1;
            go_up    = (last_dir_q == DirUp);
          end else if (calls_ahead(pending_q, floor_q, last_dir_q != DirUp)) begin
            go_valid = 1'b1;
            go_up    = (last_dir_q != DirUp);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_valid) begin
      state_d    = go_up ? StMoveUp : StMoveDown;
      last_dir_d = go_up ? DirUp : DirDown;
      tt_load    = 1'b1;
    end

    pending_d = pending_q | elev_io.callReq;
    if (state_d == StDoorOpen) pending_d[floor_d] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_dir_q <= DirUp;
      floor_q    <= '0;
      pending_q  <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      door_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      floor_q    <= floor_d;
      pending_q  <= pending_d;
      up_q       <= (state_d == StMoveUp);
      down_q     <= (state_d == StMoveDown);
      door_q     <= (state_d == StDoorOpen);
    end
  end

  elev_timer #(.Width(TimerW)) u_travel_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tt_load),
    .load_val_i (TimerW'(TRAVEL_CYCLES - 1)),
    .en_i       (state_q == StMoveUp || state_q == StMoveDown),
    .done_o     (tt_done)
  );

  elev_timer #(.Width(TimerW)) u_door_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dt_load),
    .load_val_i (TimerW'(DOOR_CYCLES - 1)),
    .en_i       (state_q == StDoorOpen),
    .done_o     (dt_done)
  );

  assign elev_io.currentFloor = floor_q;
  assign elev_io.up           = up_q;
  assign elev_io.down         = down_q;
  assign elev_io.doorIsOpen   = door_q;
  assign elev_io.pending      = pending_q;

endmodule
